// File: rtl/matrix_stream_receiver.sv
// matrix_stream_receiver
//   Deserialises a UART byte stream into complex matrix entries. A start pulse
//   opens a transfer; each signed component arrives least-significant byte
//   first. Entries are emitted row-major with the real part before the
//   imaginary part, for MATRIX_COUNT consecutive matrices. A transfer is
//   abandoned if the gap between bytes reaches TIMEOUT_CYCLES (0 = never).
// Ports
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   start           begin or restart a transfer (wins over received_ready)
//   received_byte   incoming byte, qualified by received_ready
//   entry_*         assembled component and its indices, qualified by entry_valid
//   busy            high while a transfer is in progress
//   done            pulse with the final entry_valid of a transfer
//   timeout_error   pulse when a transfer is abandoned for inactivity
module matrix_stream_receiver #(
   parameter int NUMBER_BITS    = 37,
   parameter int MATRIX_DIM     = 2,
   parameter int MATRIX_COUNT   = 1,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int MW = (MATRIX_COUNT > 1) ? $clog2(MATRIX_COUNT) : 1,
   localparam int DW = (MATRIX_DIM > 1) ? $clog2(MATRIX_DIM) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [7:0]             received_byte,
   input  logic                   received_ready,
   output logic [NUMBER_BITS-1:0] entry_value,
   output logic                   entry_valid,
   output logic [MW-1:0]          entry_matrix,
   output logic [DW-1:0]          entry_row,
   output logic [DW-1:0]          entry_col,
   output logic                   entry_imag,
   output logic                   busy,
   output logic                   done,
   output logic                   timeout_error
);

   localparam int BPN = (NUMBER_BITS + 7) / 8;
   localparam int SHW = BPN * 8;
   localparam int BW  = (BPN > 1) ? $clog2(BPN) : 1;
   localparam int TW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_RECEIVE = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [BW-1:0]          byte_cnt_q, byte_cnt_d;
   logic [TW-1:0]          to_cnt_q, to_cnt_d;
   logic [TW-1:0]          to_inc_s;
   logic [SHW-1:0]         shift_q, shift_d;
   logic                   imag_cnt_q, imag_cnt_d;
   logic [DW-1:0]          col_cnt_q, col_cnt_d;
   logic [DW-1:0]          row_cnt_q, row_cnt_d;
   logic [MW-1:0]          mat_cnt_q, mat_cnt_d;
   logic                   last_entry_s;
   logic [NUMBER_BITS-1:0] entry_value_q, entry_value_d;
   logic                   entry_valid_q, entry_valid_d;
   logic [MW-1:0]          entry_matrix_q, entry_matrix_d;
   logic [DW-1:0]          entry_row_q, entry_row_d;
   logic [DW-1:0]          entry_col_q, entry_col_d;
   logic                   entry_imag_q, entry_imag_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   timeout_error_q, timeout_error_d;

   // Next-state: byte assembly, entry index walk, timeout and transfer control
   always_comb begin
      state_d         = state_q;
      byte_cnt_d      = byte_cnt_q;
      to_cnt_d        = to_cnt_q;
      to_inc_s        = to_cnt_q + TW'(1);
      shift_d         = shift_q;
      imag_cnt_d      = imag_cnt_q;
      col_cnt_d       = col_cnt_q;
      row_cnt_d       = row_cnt_q;
      mat_cnt_d       = mat_cnt_q;
      entry_value_d   = entry_value_q;
      entry_matrix_d  = entry_matrix_q;
      entry_row_d     = entry_row_q;
      entry_col_d     = entry_col_q;
      entry_imag_d    = entry_imag_q;
      entry_valid_d   = 1'b0;
      done_d          = 1'b0;
      timeout_error_d = 1'b0;
      last_entry_s    = (imag_cnt_q == 1'b1) &&
                        (col_cnt_q == DW'(MATRIX_DIM - 1)) &&
                        (row_cnt_q == DW'(MATRIX_DIM - 1)) &&
                        (mat_cnt_q == MW'(MATRIX_COUNT - 1));

      if (start) begin
         // A start in any state reopens the transfer; a byte in this cycle is dropped.
         state_d    = ST_RECEIVE;
         byte_cnt_d = '0;
         to_cnt_d   = '0;
         imag_cnt_d = 1'b0;
         col_cnt_d  = '0;
         row_cnt_d  = '0;
         mat_cnt_d  = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_RECEIVE: begin
               if (received_ready) begin
                  // An accepted byte always beats a timeout in the same cycle.
                  to_cnt_d = '0;
                  shift_d[{byte_cnt_q, 3'b000} +: 8] = received_byte;
                  if (byte_cnt_q == BW'(BPN - 1)) begin
                     byte_cnt_d     = '0;
                     entry_valid_d  = 1'b1;
                     entry_value_d  = shift_d[NUMBER_BITS-1:0];
                     entry_matrix_d = mat_cnt_q;
                     entry_row_d    = row_cnt_q;
                     entry_col_d    = col_cnt_q;
                     entry_imag_d   = imag_cnt_q;
                     // Index walk: imag fastest, then col, row, matrix.
                     if (imag_cnt_q == 1'b0) begin
                        imag_cnt_d = 1'b1;
                     end else begin
                        imag_cnt_d = 1'b0;
                        if (col_cnt_q == DW'(MATRIX_DIM - 1)) begin
                           col_cnt_d = '0;
                           if (row_cnt_q == DW'(MATRIX_DIM - 1)) begin
                              row_cnt_d = '0;
                              mat_cnt_d = mat_cnt_q + MW'(1);
                           end else begin
                              row_cnt_d = row_cnt_q + DW'(1);
                           end
                        end else begin
                           col_cnt_d = col_cnt_q + DW'(1);
                        end
                     end
                     if (last_entry_s) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                     end else begin
                        state_d = ST_RECEIVE;
                     end
                  end else begin
                     byte_cnt_d = byte_cnt_q + BW'(1);
                  end
               end else begin
                  if ((TIMEOUT_CYCLES != 0) && (to_inc_s == TW'(TIMEOUT_CYCLES))) begin
                     timeout_error_d = 1'b1;
                     to_cnt_d        = '0;
                     state_d         = ST_IDLE;
                  end else begin
                     to_cnt_d = to_inc_s;
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      busy_d = (state_d == ST_RECEIVE);
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         byte_cnt_q      <= '0;
         to_cnt_q        <= '0;
         shift_q         <= '0;
         imag_cnt_q      <= 1'b0;
         col_cnt_q       <= '0;
         row_cnt_q       <= '0;
         mat_cnt_q       <= '0;
         entry_value_q   <= '0;
         entry_valid_q   <= 1'b0;
         entry_matrix_q  <= '0;
         entry_row_q     <= '0;
         entry_col_q     <= '0;
         entry_imag_q    <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         timeout_error_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         byte_cnt_q      <= byte_cnt_d;
         to_cnt_q        <= to_cnt_d;
         shift_q         <= shift_d;
         imag_cnt_q      <= imag_cnt_d;
         col_cnt_q       <= col_cnt_d;
         row_cnt_q       <= row_cnt_d;
         mat_cnt_q       <= mat_cnt_d;
         entry_value_q   <= entry_value_d;
         entry_valid_q   <= entry_valid_d;
         entry_matrix_q  <= entry_matrix_d;
         entry_row_q     <= entry_row_d;
         entry_col_q     <= entry_col_d;
         entry_imag_q    <= entry_imag_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         timeout_error_q <= timeout_error_d;
      end
   end

   assign entry_value   = entry_value_q;
   assign entry_valid   = entry_valid_q;
   assign entry_matrix  = entry_matrix_q;
   assign entry_row     = entry_row_q;
   assign entry_col     = entry_col_q;
   assign entry_imag    = entry_imag_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign timeout_error = timeout_error_q;

endmodule

// File: tb/tb_matrix_stream_receiver.sv
// Bench for matrix_stream_receiver. Two instances share one input stream:
// dut0 uses default parameters (one matrix, timeout 1024), dut1 uses two
// matrices and a 16-cycle timeout. A transfer-level model predicts every
// output of both instances each cycle; literal expectations pin the model.
module tb_matrix_stream_receiver;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] received_byte;
   logic       received_ready;

   logic [36:0] a_val, b_val;
   logic        a_valid, b_valid, a_mat, b_mat, a_row, b_row, a_col, b_col;
   logic        a_imag, b_imag, a_busy, b_busy, a_done, b_done, a_err, b_err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   matrix_stream_receiver u_dut0 (
      .clk(clk), .reset(reset), .start(start), .received_byte(received_byte),
      .received_ready(received_ready), .entry_value(a_val), .entry_valid(a_valid),
      .entry_matrix(a_mat), .entry_row(a_row), .entry_col(a_col), .entry_imag(a_imag),
      .busy(a_busy), .done(a_done), .timeout_error(a_err));

   matrix_stream_receiver #(.NUMBER_BITS(37), .MATRIX_DIM(2), .MATRIX_COUNT(2),
                            .TIMEOUT_CYCLES(16)) u_dut1 (
      .clk(clk), .reset(reset), .start(start), .received_byte(received_byte),
      .received_ready(received_ready), .entry_value(b_val), .entry_valid(b_valid),
      .entry_matrix(b_mat), .entry_row(b_row), .entry_col(b_col), .entry_imag(b_imag),
      .busy(b_busy), .done(b_done), .timeout_error(b_err));

   // ---------------- transfer-level model ----------------
   int          m_mc [2];
   int          m_to [2];
   bit          m_active [2];
   int          m_nb [2];
   int          m_ent [2];
   int          m_idle [2];
   logic [63:0] m_acc [2];
   logic        e_valid [2];
   logic [36:0] e_value [2];
   logic        e_mat [2], e_row [2], e_col [2], e_imag [2];
   logic        e_busy [2], e_done [2], e_err [2];

   task automatic model_step(input int d);
      e_valid[d] = 1'b0;
      e_done[d]  = 1'b0;
      e_err[d]   = 1'b0;
      if (reset) begin
         m_active[d] = 1'b0;
         m_nb[d] = 0; m_ent[d] = 0; m_idle[d] = 0; m_acc[d] = 64'd0;
         e_value[d] = 37'd0;
         e_mat[d] = 1'b0; e_row[d] = 1'b0; e_col[d] = 1'b0; e_imag[d] = 1'b0;
      end else if (start) begin
         m_active[d] = 1'b1;
         m_nb[d] = 0; m_ent[d] = 0; m_idle[d] = 0; m_acc[d] = 64'd0;
      end else if (m_active[d]) begin
         if (received_ready) begin
            m_acc[d] = m_acc[d] | (64'(received_byte) << (8 * m_nb[d]));
            m_nb[d]++;
            m_idle[d] = 0;
            if (m_nb[d] == 5) begin
               e_valid[d] = 1'b1;
               e_value[d] = m_acc[d][36:0];
               e_imag[d]  = 1'(m_ent[d] % 2);
               e_col[d]   = 1'((m_ent[d] / 2) % 2);
               e_row[d]   = 1'((m_ent[d] / 4) % 2);
               e_mat[d]   = 1'(m_ent[d] / 8);
               m_ent[d]++;
               m_nb[d]  = 0;
               m_acc[d] = 64'd0;
               if (m_ent[d] == 8 * m_mc[d]) begin
                  e_done[d]   = 1'b1;
                  m_active[d] = 1'b0;
               end
            end
         end else begin
            m_idle[d]++;
            if (m_idle[d] == m_to[d]) begin
               e_err[d]    = 1'b1;
               m_active[d] = 1'b0;
            end
         end
      end
      e_busy[d] = m_active[d];
   endtask

   initial begin
      m_mc[0] = 1; m_mc[1] = 2;
      m_to[0] = 1024; m_to[1] = 16;
      for (int d = 0; d < 2; d++) begin
         m_active[d] = 1'b0; m_nb[d] = 0; m_ent[d] = 0; m_idle[d] = 0; m_acc[d] = 64'd0;
         e_valid[d] = 1'b0; e_value[d] = 37'd0; e_mat[d] = 1'b0; e_row[d] = 1'b0;
         e_col[d] = 1'b0; e_imag[d] = 1'b0; e_busy[d] = 1'b0; e_done[d] = 1'b0;
         e_err[d] = 1'b0;
      end
      forever begin
         @(posedge clk);
         model_step(0);
         model_step(1);
      end
   end

   // ---------------- checking ----------------
   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
      end
   endtask

   task automatic chk_dut(input int d, input logic v, input logic [36:0] val, input logic m,
                          input logic r, input logic c, input logic im, input logic b,
                          input logic dn, input logic er);
      cmp($sformatf("dut%0d_valid", d), 64'(v), 64'(e_valid[d]));
      cmp($sformatf("dut%0d_value", d), 64'(val), 64'(e_value[d]));
      cmp($sformatf("dut%0d_matrix", d), 64'(m), 64'(e_mat[d]));
      cmp($sformatf("dut%0d_row", d), 64'(r), 64'(e_row[d]));
      cmp($sformatf("dut%0d_col", d), 64'(c), 64'(e_col[d]));
      cmp($sformatf("dut%0d_imag", d), 64'(im), 64'(e_imag[d]));
      cmp($sformatf("dut%0d_busy", d), 64'(b), 64'(e_busy[d]));
      cmp($sformatf("dut%0d_done", d), 64'(dn), 64'(e_done[d]));
      cmp($sformatf("dut%0d_timeout", d), 64'(er), 64'(e_err[d]));
   endtask

   int          a_strobes = 0, a_dones = 0, b_strobes = 0, b_dones = 0, b_errs = 0;
   bit          cap_a = 1'b0, arm_b = 1'b0;
   logic [36:0] qa_val [$];
   logic [2:0]  qa_idx [$];
   logic        qa_done [$];
   logic [36:0] b_first_val;
   logic [3:0]  b_first_idx;

   // Per-cycle compare against the model, plus event counters for literal checks
   initial begin
      forever begin
         @(negedge clk);
         chk_dut(0, a_valid, a_val, a_mat, a_row, a_col, a_imag, a_busy, a_done, a_err);
         chk_dut(1, b_valid, b_val, b_mat, b_row, b_col, b_imag, b_busy, b_done, b_err);
         if (a_valid) a_strobes++;
         if (a_done)  a_dones++;
         if (b_valid) b_strobes++;
         if (b_done)  b_dones++;
         if (b_err)   b_errs++;
         if (cap_a && a_valid) begin
            qa_val.push_back(a_val);
            qa_idx.push_back({a_row, a_col, a_imag});
            qa_done.push_back(a_done);
         end
         if (arm_b && b_valid) begin
            b_first_val = b_val;
            b_first_idx = {b_mat, b_row, b_col, b_imag};
            arm_b = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers (called at a falling edge) ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      received_ready = 1'b1;
      received_byte  = b;
      @(negedge clk);
      received_ready = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_num(input logic [36:0] v);
      logic [39:0] w;
      w = 40'(v);
      for (int k = 0; k < 5; k++) send_byte(w[8*k +: 8]);
   endtask

   task automatic send_random(input int n);
      for (int k = 0; k < n; k++) begin
         send_byte(8'($urandom));
         idle($urandom_range(0, 2));
      end
   endtask

   logic [36:0] t1_vals [8];
   int s_a, s_b, s_ad, s_bd, s_be, nbytes, sel;

   initial begin
      reset = 1'b1; start = 1'b0; received_ready = 1'b0; received_byte = 8'h00;
      idle(3);
      cmp("rst_busy", 64'(a_busy), 64'd0);
      cmp("rst_value", 64'(a_val), 64'd0);
      cmp("rst_valid", 64'(b_valid), 64'd0);
      reset = 1'b0;
      // IDLE ignores bytes
      send_byte(8'h5A); send_byte(8'hA5);
      idle(2);

      // Test 1: four complex numbers, each with zero imaginary part
      t1_vals[0] = 37'h5A82799A0; t1_vals[1] = 37'h0;
      t1_vals[2] = 37'h5A82799A1; t1_vals[3] = 37'h0;
      t1_vals[4] = 37'h5A82799A2; t1_vals[5] = 37'h0;
      t1_vals[6] = 37'h1A57D8665D; t1_vals[7] = 37'h0;
      cap_a = 1'b1;
      pulse_start();
      send_num(37'h5A82799A0);   send_num(37'h0);
      send_num(37'h5A82799A1);   send_num(37'h0);
      send_num(37'h5A82799A2);   send_num(37'h0);
      send_num(-37'sd24296004003); send_num(37'h0);
      idle(2);
      cap_a = 1'b0;
      cmp("t1_strobes", 64'(qa_val.size()), 64'd8);
      for (int k = 0; k < 8 && k < qa_val.size(); k++) begin
         cmp($sformatf("t1_value%0d", k), 64'(qa_val[k]), 64'(t1_vals[k]));
         cmp($sformatf("t1_index%0d", k), 64'(qa_idx[k]), 64'(k));
         cmp($sformatf("t1_done%0d", k), 64'(qa_done[k]), 64'(k == 7));
      end
      idle(18);   // dut1 abandons its half-finished two-matrix transfer

      // Test 2: single entry latency and dropped top bits of the last byte
      pulse_start();
      send_byte(8'hA0); send_byte(8'h99); send_byte(8'h27); send_byte(8'hA8);
      cmp("t2_early_valid", 64'(a_valid), 64'd0);
      send_byte(8'h05);
      cmp("t2_valid", 64'(a_valid), 64'd1);
      cmp("t2_value", 64'(a_val), 64'h5A82799A0);
      pulse_start();
      send_byte(8'hA0); send_byte(8'h99); send_byte(8'h27); send_byte(8'hA8);
      send_byte(8'hFD);
      cmp("t2_trunc_value", 64'(a_val), 64'h1DA82799A0);
      idle(20);

      // Test 3: two-matrix transfer on dut1
      s_a = a_strobes; s_b = b_strobes; s_ad = a_dones; s_bd = b_dones;
      pulse_start();
      send_random(80);
      idle(3);
      cmp("t3_b_strobes", 64'(b_strobes - s_b), 64'd16);
      cmp("t3_b_dones", 64'(b_dones - s_bd), 64'd1);
      cmp("t3_a_strobes", 64'(a_strobes - s_a), 64'd8);
      cmp("t3_a_dones", 64'(a_dones - s_ad), 64'd1);

      // Test 4: 16-cycle inactivity aborts dut1, later bytes ignored there
      s_be = b_errs; s_b = b_strobes;
      pulse_start();
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
      idle(17);
      cmp("t4_timeout", 64'(b_errs - s_be), 64'd1);
      cmp("t4_b_busy", 64'(b_busy), 64'd0);
      cmp("t4_a_busy", 64'(a_busy), 64'd1);
      send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
      idle(2);
      cmp("t4_no_entry", 64'(b_strobes - s_b), 64'd0);
      idle(18);

      // Test 5: restart with a coincident byte, then a clean transfer
      pulse_start();
      send_random(7);
      start = 1'b1; received_ready = 1'b1; received_byte = 8'hEE;
      @(negedge clk);
      start = 1'b0; received_ready = 1'b0;
      arm_b = 1'b1;
      send_num(37'h0123456789);
      idle(1);
      cmp("t5_first_value", 64'(b_first_val), 64'h0123456789);
      cmp("t5_first_index", 64'(b_first_idx), 64'd0);
      send_random(75);
      idle(3);

      // Test 6: reset mid-number, then a normal transfer
      pulse_start();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      reset = 1'b1;
      @(negedge clk);
      cmp("t6_busy", 64'(b_busy), 64'd0);
      cmp("t6_value", 64'(a_val), 64'd0);
      cmp("t6_index", 64'({b_mat, b_row, b_col, b_imag}), 64'd0);
      reset = 1'b0;
      s_bd = b_dones; s_ad = a_dones;
      pulse_start();
      send_random(80);
      idle(3);
      cmp("t6_b_done", 64'(b_dones - s_bd), 64'd1);
      cmp("t6_a_done", 64'(a_dones - s_ad), 64'd1);

      // Random traffic: restarts, gaps, timeouts, stray bytes, resets
      for (int it = 0; it < 30; it++) begin
         sel    = $urandom_range(0, 9);
         nbytes = $urandom_range(0, 85);
         if (sel == 0) begin
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         if (sel == 2) send_random(3);
         start = 1'b1;
         received_ready = 1'($urandom_range(0, 1));
         received_byte  = 8'($urandom);
         @(negedge clk);
         start = 1'b0; received_ready = 1'b0;
         send_random(nbytes);
         if (sel == 1) idle(20);
      end
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
